// File: rtl/placement_registry_pkg.sv
// Shared parameters for the placement registry: playfield coordinate widths,
// table sizes and the exclusion radii used for nests and sugar patches.
package placement_registry_pkg;

    localparam int X_bits            = 8;
    localparam int Y_bits            = 8;
    localparam int NEST_num          = 4;
    localparam int SUGARPATCH_num    = 4;
    localparam int NEST_RADIUS       = 8;
    localparam int SUGARPATCH_RADIUS = 4;

    // Index width for a table of n entries, with one spare bit so that
    // out-of-range ids can still be presented on the write port.
    function automatic int num_bits(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int NEST_num_bits       = num_bits(NEST_num);
    localparam int SUGARPATCH_num_bits = num_bits(SUGARPATCH_num);

    typedef enum logic {
        KIND_NEST  = 1'b0,
        KIND_PATCH = 1'b1
    } kind_e;

endpackage

// File: rtl/placement_registry_proximity_cmp.sv
// Combinational proximity check: two points are "near" when both axis
// distances are strictly below the exclusion threshold.
module proximity_cmp #(
    parameter int X_bits = placement_registry_pkg::X_bits,
    parameter int Y_bits = placement_registry_pkg::Y_bits,
    parameter int T_bits = 10
) (
    input  logic [X_bits-1:0] ax,
    input  logic [Y_bits-1:0] ay,
    input  logic [X_bits-1:0] bx,
    input  logic [Y_bits-1:0] by,
    input  logic [T_bits-1:0] thresh,
    output logic              near
);

    logic [X_bits:0] dx;
    logic [Y_bits:0] dy;

    // Absolute differences are formed one bit wider so nothing wraps.
    always_comb begin
        if (ax >= bx) dx = {1'b0, ax} - {1'b0, bx};
        else          dx = {1'b0, bx} - {1'b0, ax};
        if (ay >= by) dy = {1'b0, ay} - {1'b0, by};
        else          dy = {1'b0, by} - {1'b0, ay};
        near = (T_bits'(dx) < thresh) && (T_bits'(dy) < thresh);
    end

endmodule

// File: rtl/placement_registry.sv
// Placement registry: stores nest and sugar-patch centers and answers
// collision queries by scanning the stored entries one per cycle.
module placement_registry #(
    parameter int NEST_num          = placement_registry_pkg::NEST_num,
    parameter int SUGARPATCH_num    = placement_registry_pkg::SUGARPATCH_num,
    parameter int X_bits            = placement_registry_pkg::X_bits,
    parameter int Y_bits            = placement_registry_pkg::Y_bits,
    parameter int NEST_RADIUS       = placement_registry_pkg::NEST_RADIUS,
    parameter int SUGARPATCH_RADIUS = placement_registry_pkg::SUGARPATCH_RADIUS,
    localparam int NEST_NB  = placement_registry_pkg::num_bits(NEST_num),
    localparam int PATCH_NB = placement_registry_pkg::num_bits(SUGARPATCH_num),
    localparam int ID_bits  = (NEST_NB > PATCH_NB) ? NEST_NB : PATCH_NB
) (
    input  logic                local_clock,
    input  logic                RESET_SIM,
    input  logic                wr_en,
    input  logic                wr_kind,
    input  logic [ID_bits-1:0]  wr_id,
    input  logic [X_bits-1:0]   wr_x,
    input  logic [Y_bits-1:0]   wr_y,
    input  logic                q_valid,
    input  logic                q_kind,
    input  logic [X_bits-1:0]   q_x,
    input  logic [Y_bits-1:0]   q_y,
    output logic                q_ready,
    output logic                rsp_valid,
    output logic                collision,
    output logic [X_bits-1:0]   nests_X   [NEST_num],
    output logic [Y_bits-1:0]   nests_Y   [NEST_num],
    output logic [X_bits-1:0]   patches_X [SUGARPATCH_num],
    output logic [Y_bits-1:0]   patches_Y [SUGARPATCH_num],
    output logic [NEST_NB:0]    nest_count,
    output logic [PATCH_NB:0]   patch_count
);

    import placement_registry_pkg::*;

    localparam int TOTAL    = NEST_num + SUGARPATCH_num;
    localparam int IDX_bits = $clog2(TOTAL + 1);
    localparam int T_bits   = ((X_bits > Y_bits) ? X_bits : Y_bits) + 2;

    localparam logic [IDX_bits-1:0] LAST_IDX = IDX_bits'(TOTAL - 1);
    localparam logic [T_bits-1:0]   E_NN = T_bits'(2 * NEST_RADIUS);
    localparam logic [T_bits-1:0]   E_NP = T_bits'(NEST_RADIUS + SUGARPATCH_RADIUS);
    localparam logic [T_bits-1:0]   E_PP = T_bits'(2 * SUGARPATCH_RADIUS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_bits-1:0]   idx_q, idx_d;
    logic                  hit_q, hit_d;
    logic                  latch_query;

    logic [NEST_num-1:0]       nest_valid;
    logic [SUGARPATCH_num-1:0] patch_valid;

    logic                q_kind_r;
    logic [X_bits-1:0]   q_x_r;
    logic [Y_bits-1:0]   q_y_r;

    logic [X_bits-1:0]   ent_x;
    logic [Y_bits-1:0]   ent_y;
    logic                ent_valid;
    logic                ent_kind;
    logic [T_bits-1:0]   thresh;
    logic                near;

    // Table storage and occupancy counts; a rewrite of a valid slot keeps its count.
    always_ff @(posedge local_clock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            for (int i = 0; i < NEST_num; i++) begin
                nests_X[i] <= '0;
                nests_Y[i] <= '0;
            end
            for (int j = 0; j < SUGARPATCH_num; j++) begin
                patches_X[j] <= '0;
                patches_Y[j] <= '0;
            end
            nest_valid  <= '0;
            patch_valid <= '0;
            nest_count  <= '0;
            patch_count <= '0;
        end else if (wr_en) begin
            if (wr_kind == KIND_NEST) begin
                for (int i = 0; i < NEST_num; i++) begin
                    if (wr_id == ID_bits'(i)) begin
                        nests_X[i]    <= wr_x;
                        nests_Y[i]    <= wr_y;
                        nest_valid[i] <= 1'b1;
                        if (!nest_valid[i]) nest_count <= nest_count + 1'b1;
                    end
                end
            end else begin
                for (int j = 0; j < SUGARPATCH_num; j++) begin
                    if (wr_id == ID_bits'(j)) begin
                        patches_X[j]   <= wr_x;
                        patches_Y[j]   <= wr_y;
                        patch_valid[j] <= 1'b1;
                        if (!patch_valid[j]) patch_count <= patch_count + 1'b1;
                    end
                end
            end
        end
    end

    // Select the entry addressed by the scan index: nests first, then patches.
    always_comb begin
        ent_x     = '0;
        ent_y     = '0;
        ent_valid = 1'b0;
        ent_kind  = KIND_NEST;
        for (int i = 0; i < NEST_num; i++) begin
            if (idx_q == IDX_bits'(i)) begin
                ent_x     = nests_X[i];
                ent_y     = nests_Y[i];
                ent_valid = nest_valid[i];
                ent_kind  = KIND_NEST;
            end
        end
        for (int j = 0; j < SUGARPATCH_num; j++) begin
            if (idx_q == IDX_bits'(NEST_num + j)) begin
                ent_x     = patches_X[j];
                ent_y     = patches_Y[j];
                ent_valid = patch_valid[j];
                ent_kind  = KIND_PATCH;
            end
        end
    end

    // Exclusion distance is the sum of the two objects' radii.
    always_comb begin
        thresh = E_NP;
        if (q_kind_r == ent_kind) thresh = (q_kind_r == KIND_PATCH) ? E_PP : E_NN;
    end

    proximity_cmp #(
        .X_bits (X_bits),
        .Y_bits (Y_bits),
        .T_bits (T_bits)
    ) u_cmp (
        .ax     (q_x_r),
        .ay     (q_y_r),
        .bx     (ent_x),
        .by     (ent_y),
        .thresh (thresh),
        .near   (near)
    );

    // Scan controller: accept in IDLE, walk entries with early exit on hit, report in DONE.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        latch_query = 1'b0;
        case (state_q)
            IDLE: begin
                if (q_valid) begin
                    latch_query = 1'b1;
                    idx_d       = '0;
                    hit_d       = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (ent_valid && near) begin
                    hit_d   = 1'b1;
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge local_clock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
        end
    end

    // Hold the candidate while the scan runs so the requester may move on.
    always_ff @(posedge local_clock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            q_kind_r <= 1'b0;
            q_x_r    <= '0;
            q_y_r    <= '0;
        end else if (latch_query) begin
            q_kind_r <= q_kind;
            q_x_r    <= q_x;
            q_y_r    <= q_y;
        end
    end

    // Result is loaded as the scan ends so it is already valid during the DONE pulse.
    always_ff @(posedge local_clock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            collision <= 1'b0;
        end else if (state_q == SCAN && state_d == DONE) begin
            collision <= hit_d;
        end
    end

    assign q_ready   = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);

endmodule

// File: tb/tb_placement_registry.sv
// Scoreboard testbench for placement_registry: directed boundary cases then
// randomized queries with writes interleaved into the scan window.
module tb_placement_registry;

    import placement_registry_pkg::*;

    localparam int IDW = (NEST_num_bits > SUGARPATCH_num_bits) ? NEST_num_bits : SUGARPATCH_num_bits;
    localparam int TOT = NEST_num + SUGARPATCH_num;

    logic                       local_clock = 1'b0;
    logic                       RESET_SIM   = 1'b1;
    logic                       wr_en = 1'b0, wr_kind = 1'b0;
    logic [IDW-1:0]             wr_id = '0;
    logic [X_bits-1:0]          wr_x = '0, q_x = '0;
    logic [Y_bits-1:0]          wr_y = '0, q_y = '0;
    logic                       q_valid = 1'b0, q_kind = 1'b0;
    logic                       q_ready, rsp_valid, collision;
    logic [X_bits-1:0]          nests_X   [NEST_num];
    logic [Y_bits-1:0]          nests_Y   [NEST_num];
    logic [X_bits-1:0]          patches_X [SUGARPATCH_num];
    logic [Y_bits-1:0]          patches_Y [SUGARPATCH_num];
    logic [NEST_num_bits:0]       nest_count;
    logic [SUGARPATCH_num_bits:0] patch_count;

    placement_registry dut (
        .local_clock (local_clock), .RESET_SIM (RESET_SIM),
        .wr_en (wr_en), .wr_kind (wr_kind), .wr_id (wr_id), .wr_x (wr_x), .wr_y (wr_y),
        .q_valid (q_valid), .q_kind (q_kind), .q_x (q_x), .q_y (q_y),
        .q_ready (q_ready), .rsp_valid (rsp_valid), .collision (collision),
        .nests_X (nests_X), .nests_Y (nests_Y), .patches_X (patches_X), .patches_Y (patches_Y),
        .nest_count (nest_count), .patch_count (patch_count)
    );

    always #5 local_clock = ~local_clock;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;

    typedef struct {
        int due;
        int coll;
        int ncnt;
        int pcnt;
    } exp_t;
    exp_t sb[$];

    // Reference tables, indexed [kind][id].
    int mx [2][8];
    int my [2][8];
    bit mv [2][8];
    int mcnt [2];

    // Writes planned at cycle offsets 1..TOT after the query is accepted.
    bit pen [16];
    int pk [16], pid [16], px [16], py [16];

    function automatic int rad(input int k);
        return (k != 0) ? SUGARPATCH_RADIUS : NEST_RADIUS;
    endfunction

    function automatic int tsize(input int k);
        return (k != 0) ? SUGARPATCH_num : NEST_num;
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic void m_write(input int k, input int id, input int x, input int y);
        if (id < tsize(k)) begin
            if (!mv[k][id]) mcnt[k]++;
            mv[k][id] = 1'b1;
            mx[k][id] = x;
            my[k][id] = y;
        end
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            for (int i = 0; i < 8; i++) begin
                mx[k][i] = 0; my[k][i] = 0; mv[k][i] = 1'b0;
            end
        end
    endfunction

    function automatic void clear_plan();
        for (int j = 0; j < 16; j++) pen[j] = 1'b0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, ncyc);
        end
    endtask

    task automatic compare_tables();
        for (int i = 0; i < NEST_num; i++) begin
            checkOutput($sformatf("nests_X[%0d]", i), int'(nests_X[i]), mx[0][i]);
            checkOutput($sformatf("nests_Y[%0d]", i), int'(nests_Y[i]), my[0][i]);
        end
        for (int i = 0; i < SUGARPATCH_num; i++) begin
            checkOutput($sformatf("patches_X[%0d]", i), int'(patches_X[i]), mx[1][i]);
            checkOutput($sformatf("patches_Y[%0d]", i), int'(patches_Y[i]), my[1][i]);
        end
    endtask

    // Monitor: pops the scoreboard on each response and flags late or unexpected ones.
    always @(negedge local_clock) begin
        exp_t e;
        ncyc++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected no pending query", ncyc);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_cycle", ncyc, e.due);
                checkOutput("collision", int'(collision), e.coll);
                checkOutput("nest_count", int'(nest_count), e.ncnt);
                checkOutput("patch_count", int'(patch_count), e.pcnt);
            end
        end else if (sb.size() > 0 && ncyc > sb[0].due) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL missing_rsp: got no rsp_valid by cycle %0d, expected at cycle %0d", ncyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic do_write(input int k, input int id, input int x, input int y);
        wr_en = 1'b1; wr_kind = k[0]; wr_id = IDW'(id); wr_x = X_bits'(x); wr_y = Y_bits'(y);
        m_write(k, id, x, y);
        @(negedge local_clock); #1;
        wr_en = 1'b0;
    endtask

    // Issue one query; the reference decides the outcome entry by entry, applying
    // a planned write before an entry only if it lands no later than that entry's compare.
    task automatic applyStimulus(input int k, input int x, input int y);
        int  lat;
        int  last;
        int  hit;
        int  ek, eid, e_thr;
        checkOutput("q_ready", int'(q_ready), 1);
        hit  = 0;
        lat  = TOT + 1;
        last = 0;
        for (int e = 0; e < TOT; e++) begin
            if (e >= 1 && pen[e]) m_write(pk[e], pid[e], px[e], py[e]);
            last  = e;
            ek    = (e < NEST_num) ? 0 : 1;
            eid   = (ek == 0) ? e : e - NEST_num;
            e_thr = rad(k) + rad(ek);
            if (mv[ek][eid] && absd(x, mx[ek][eid]) < e_thr && absd(y, my[ek][eid]) < e_thr) begin
                hit = 1;
                lat = e + 2;
                break;
            end
        end
        for (int j = last + 1; j <= lat - 1; j++) if (pen[j]) m_write(pk[j], pid[j], px[j], py[j]);
        sb.push_back('{due: ncyc + lat, coll: hit, ncnt: mcnt[0], pcnt: mcnt[1]});

        q_valid = 1'b1; q_kind = k[0]; q_x = X_bits'(x); q_y = Y_bits'(y);
        @(negedge local_clock); #1;
        for (int j = 1; j <= lat; j++) begin
            if (j <= lat - 1 && pen[j]) begin
                wr_en = 1'b1; wr_kind = pk[j][0]; wr_id = IDW'(pid[j]);
                wr_x = X_bits'(px[j]); wr_y = Y_bits'(py[j]);
            end else begin
                wr_en = 1'b0;
            end
            q_valid = 1'($urandom_range(0, 1));
            q_kind  = 1'($urandom_range(0, 1));
            q_x     = X_bits'($urandom_range(40, 80));
            q_y     = Y_bits'($urandom_range(40, 80));
            @(negedge local_clock); #1;
        end
        q_valid = 1'b0;
        wr_en   = 1'b0;
        compare_tables();
    endtask

    task automatic reset_mid_scan();
        q_valid = 1'b1; q_kind = 1'b0; q_x = 8'd10; q_y = 8'd10;
        @(negedge local_clock); #1;
        q_valid = 1'b0;
        repeat (2) begin @(negedge local_clock); #1; end
        RESET_SIM = 1'b1;
        m_reset();
        @(negedge local_clock); #1;
        checkOutput("rst_q_ready", int'(q_ready), 1);
        checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
        checkOutput("rst_collision", int'(collision), 0);
        checkOutput("rst_nest_count", int'(nest_count), 0);
        checkOutput("rst_patch_count", int'(patch_count), 0);
        compare_tables();
        RESET_SIM = 1'b0;
        repeat (12) begin @(negedge local_clock); #1; end
    endtask

    initial begin
        m_reset();
        clear_plan();
        repeat (2) begin @(negedge local_clock); #1; end
        RESET_SIM = 1'b0;
        checkOutput("reset_q_ready", int'(q_ready), 1);
        checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
        checkOutput("reset_collision", int'(collision), 0);
        checkOutput("reset_nest_count", int'(nest_count), 0);
        compare_tables();

        // Empty table: full scan, no hit.
        applyStimulus(0, 10, 10);
        // Nest-nest distance 10 < 16 hits on entry 0; distance 20 does not.
        do_write(0, 0, 50, 40);
        applyStimulus(0, 60, 40);
        applyStimulus(0, 70, 40);
        // Patch against nest: threshold 12, 11 hits, 12 misses.
        applyStimulus(1, 61, 40);
        applyStimulus(1, 62, 40);
        // Out-of-range id is dropped; rewrite keeps the count.
        do_write(0, 5, 1, 1);
        checkOutput("nest_count_after_bad_id", int'(nest_count), mcnt[0]);
        do_write(0, 0, 55, 45);
        checkOutput("nest_count_after_rewrite", int'(nest_count), mcnt[0]);
        // A write landing before its entry's compare is seen.
        clear_plan();
        pen[2] = 1'b1; pk[2] = 0; pid[2] = 2; px[2] = 150; py[2] = 150;
        applyStimulus(0, 150, 150);
        // A write landing in the same cycle as its entry's compare is not.
        clear_plan();
        pen[1] = 1'b1; pk[1] = 0; pid[1] = 0; px[1] = 200; py[1] = 200;
        applyStimulus(0, 200, 200);
        clear_plan();

        reset_mid_scan();

        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 2))
                do_write($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(40, 80), $urandom_range(40, 80));
            clear_plan();
            for (int j = 1; j <= TOT; j++) begin
                pen[j] = ($urandom_range(0, 3) == 0);
                pk[j]  = $urandom_range(0, 1);
                pid[j] = $urandom_range(0, 5);
                px[j]  = $urandom_range(40, 80);
                py[j]  = $urandom_range(40, 80);
            end
            applyStimulus($urandom_range(0, 1), $urandom_range(30, 90), $urandom_range(30, 90));
        end
        clear_plan();

        repeat (4) begin @(negedge local_clock); #1; end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain: got %0d responses outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/placement_registry.md
PLACEMENT_REGISTRY -- requirements
Module: placement_registry

Interface
REQ-001 The block SHALL have parameters NEST_num, SUGARPATCH_num, X_bits, Y_bits, NEST_RADIUS and SUGARPATCH_RADIUS, each defaulting to the shared-package value; they size the tables and set the exclusion distances.
REQ-002 The block SHALL be clocked by local_clock and reset by RESET_SIM, asynchronous, active-high.
REQ-003 local_clock  in  1  clock for all state.
REQ-004 RESET_SIM  in  1  asynchronous active-high reset.
REQ-005 wr_en  in  1  write strobe for a placement entry.
REQ-006 wr_kind  in  1  entry type: 0 = nest, 1 = sugar patch.
REQ-007 wr_id  in  max(NEST_num_bits, SUGARPATCH_num_bits)  entry index within the selected kind.
REQ-008 wr_x / wr_y  in  X_bits / Y_bits  entry center.
REQ-009 q_valid  in  1  collision query request.
REQ-010 q_kind  in  1  type of the object being placed: 0 = nest, 1 = patch.
REQ-011 q_x / q_y  in  X_bits / Y_bits  candidate center.
REQ-012 q_ready  out  1  block is idle and accepts a query.
REQ-013 rsp_valid  out  1  one-cycle pulse; collision is valid in that cycle.
REQ-014 collision  out  1  result of the last completed query; held until the next rsp_valid.
REQ-015 nests_X / nests_Y  out  [NEST_num][X_bits] / [NEST_num][Y_bits]  stored nest centers.
REQ-016 patches_X / patches_Y  out  [SUGARPATCH_num][X_bits] / [SUGARPATCH_num][Y_bits]  stored patch centers.
REQ-017 nest_count / patch_count  out  NEST_num_bits+1 / SUGARPATCH_num_bits+1  number of valid entries of each kind.

Function
REQ-018 On a cycle with wr_en=1, the block SHALL store (wr_x, wr_y) at wr_id of wr_kind and set that entry's valid bit.
REQ-019 A write with wr_id >= table size SHALL be ignored; a rewrite of a valid entry SHALL overwrite it without changing its count.
REQ-020 The FSM SHALL have three states, IDLE, SCAN and DONE; q_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: q_valid=1 SHALL latch q_kind/q_x/q_y, clear hit, set idx=0 and move to SCAN.
REQ-022 SCAN: the block SHALL examine one entry per cycle, nests 0..NEST_num-1 then patches 0..SUGARPATCH_num-1; invalid entries never hit.
REQ-023 Hit rule: the block SHALL declare a hit when |q_x-ex| < E and |q_y-ey| < E, where E = radius(q_kind) + radius(entry kind).
REQ-024 Differences SHALL be computed at X_bits+1 / Y_bits+1 with no wrap.
REQ-025 On a hit, the FSM SHALL go to DONE with hit=1 (early exit); after the last index it SHALL go to DONE.
REQ-026 DONE: the block SHALL pulse rsp_valid=1, load collision=hit and return to IDLE.
REQ-027 Latency from q_valid accepted to rsp_valid SHALL be k+2 cycles, where k is the hit index, or NEST_num+SUGARPATCH_num+1 cycles with no hit.
REQ-028 A write during SCAN to an entry not yet scanned SHALL be seen; a write to the entry being compared in the same cycle SHALL use the old value.
REQ-029 q_valid outside IDLE SHALL be ignored and not queued.

Reset
REQ-030 RESET_SIM SHALL set: state=IDLE, all valid bits=0, all coordinates=0, counts=0, collision=0, rsp_valid=0, q_ready=1.
REQ-031 Reset mid-scan SHALL abort the scan with no rsp_valid.

Structure
REQ-032 X_bits, Y_bits, NEST_num(_bits), SUGARPATCH_num(_bits), NEST_RADIUS and SUGARPATCH_RADIUS SHALL come from the shared params package; the state enum SHALL be local.
REQ-033 There SHALL be one sub-module, proximity_cmp, a combinational abs-difference/threshold compare.

Verification (NEST_RADIUS=8, SUGARPATCH_RADIUS=4, NEST_num=4, SUGARPATCH_num=4)
REQ-034 Empty table, nest query (10,10) -> rsp_valid after 9 cycles, collision=0.
REQ-035 Nest0=(50,40); nest query (60,40) -> collision=1, rsp_valid 2 cycles after accept; query (70,40) -> collision=0 after 9 cycles.
REQ-036 Nest0=(50,40); patch query (61,40) -> 1; (62,40) -> 0 (E=12 boundary).
REQ-037 wr_id=5 nest write -> ignored, nest_count unchanged; rewrite nest0 -> nest_count stays 1.
REQ-038 RESET_SIM asserted in SCAN -> no rsp_valid, q_ready=1 next cycle, arrays=0.
